// File: rtl/cpc_ram1m_pkg.sv
// Shared definitions for the 1MB CPC RAM expansion controller: the
// configuration-write FSM states, the default I/O port decode, the
// expansion mode constants and the mode/slot -> expansion page lookup.
package cpc_ram1m_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        HOLD    = 2'd2
    } cfg_state_t;

    // A15:A11 of the RAM configuration port (&7Fxx / &7Exx)
    localparam logic [4:0] PORT_HI_DEFAULT = 5'b01111;

    localparam logic [2:0] MODE_INTERNAL = 3'd0;  // no expansion pages
    localparam logic [2:0] MODE_TOP      = 3'd1;  // slot 3 -> page 7
    localparam logic [2:0] MODE_ALL      = 3'd2;  // slots 0-3 -> pages 4-7
    localparam logic [2:0] MODE_TOP_ALT  = 3'd3;  // slot 3 -> page 7
    localparam logic [2:0] MODE_SLOT1    = 3'd4;  // 4-7: slot 1 -> page (mode)

    // Expansion page selection: hit flag plus page 4-7 encoded as 0-3
    typedef struct packed {
        logic       hit;
        logic [1:0] page;
    } ext_sel_t;

    function automatic ext_sel_t ext_page_lookup(input logic [2:0] mode,
                                                 input logic [1:0] slot);
        ext_sel_t r;
        r.hit  = 1'b0;
        r.page = 2'b00;
        case (mode)
            MODE_INTERNAL: ;
            MODE_TOP, MODE_TOP_ALT: begin
                if (slot == 2'd3) begin
                    r.hit  = 1'b1;
                    r.page = 2'b11;
                end
            end
            MODE_ALL: begin
                r.hit  = 1'b1;
                r.page = slot;
            end
            default: begin
                if (mode >= MODE_SLOT1 && slot == 2'd1) begin
                    r.hit  = 1'b1;
                    r.page = mode[1:0];
                end
            end
        endcase
        return r;
    endfunction

endpackage

// File: rtl/cpc_ram1m_map.sv
// Combinational slot mapper: turns the current mode/bank and the CPU
// 16K slot (A15:A14) into an expansion hit, SRAM A18:A14 and chip select.
module cpc_ram1m_map
    import cpc_ram1m_pkg::*;
#(
    parameter int unsigned BANK_BITS = 4
) (
    input  logic [2:0]           mode,
    input  logic [BANK_BITS-1:0] bank,
    input  logic [1:0]           slot,
    output logic                 slot_hit,
    output logic [4:0]           hiadr,
    output logic                 chip_sel
);

    ext_sel_t sel;

    // Look up which expansion page (if any) the slot maps to
    always_comb begin
        sel = ext_page_lookup(mode, slot);
    end

    assign slot_hit = sel.hit;
    assign hiadr    = {bank[2:0], sel.page};
    // Top bank bit picks which 512K SRAM holds the page
    assign chip_sel = bank[BANK_BITS-1];

endmodule

// File: rtl/cpc_ram1m_ctrl.sv
// Bank-switch controller for the 1MB CPC RAM expansion.
// Decodes OUT writes to &7Fxx/&7Exx with D7:6=11 into a bank/mode register
// (one update per OUT) and drives the SRAM strobes from that register.
// Optional macro CPC_RAM1M_TESTPOINT_EN exposes registered debug state on TP.
module cpc_ram1m_ctrl
    import cpc_ram1m_pkg::*;
#(
    parameter int unsigned BANK_BITS = 4,
    parameter logic [4:0]  PORT_HI   = PORT_HI_DEFAULT
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        ENABLE,
    input  logic [15:0] A,
    input  logic [7:0]  D,
    input  logic        IOREQ_B,
    input  logic        WR_B,
    input  logic        MREQ_B,
    input  logic        RFSH_B,
    input  logic        RAMRD_B,
    output logic [4:0]  HIADR,
    output logic        RAMCS0_B,
    output logic        RAMCS1_B,
    output logic        RAMOE_B,
    output logic        RAMWE_B,
    output logic        RAMDIS,
    output logic [4:0]  TP
);

    cfg_state_t           state, state_nxt;
    logic                 cfg_load;
    logic                 cfg_hit;
    logic [2:0]           mode;
    logic [BANK_BITS-1:0] bank;
    logic                 slot_hit;
    logic                 chip_sel;
    logic                 ext_hit;
    logic                 unused_addr;

    assign cfg_hit = ~IOREQ_B & ~WR_B & (A[15:11] == PORT_HI) & (D[7:6] == 2'b11);

    // Address bits not involved in port decode or slot selection
    assign unused_addr = ^{A[10:9], A[7:0]};

    // FSM state register
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next state: capture once, then wait for the I/O write to end
    always_comb begin
        state_nxt = state;
        cfg_load  = 1'b0;
        case (state)
            IDLE:    if (cfg_hit) state_nxt = CAPTURE;
            CAPTURE: begin
                cfg_load  = 1'b1;
                state_nxt = HOLD;
            end
            HOLD:    if (IOREQ_B | WR_B) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Bank/mode register; bank MSB comes from A8 so &7Exx selects the upper chip
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            mode <= '0;
            bank <= '0;
        end else if (cfg_load) begin
            mode <= D[2:0];
            bank <= {~A[8], D[5:3]};
        end
    end

    cpc_ram1m_map #(
        .BANK_BITS (BANK_BITS)
    ) u_map (
        .mode     (mode),
        .bank     (bank),
        .slot     (A[15:14]),
        .slot_hit (slot_hit),
        .hiadr    (HIADR),
        .chip_sel (chip_sel)
    );

    // Refresh cycles and a disabled board never touch the SRAMs
    assign ext_hit  = slot_hit & ENABLE & RFSH_B & ~MREQ_B;

    assign RAMCS0_B = ~(ext_hit & ~chip_sel);
    assign RAMCS1_B = ~(ext_hit &  chip_sel);
    assign RAMOE_B  = ~(ext_hit & ~RAMRD_B);
    assign RAMWE_B  = ~(ext_hit & ~WR_B);
    assign RAMDIS   = ext_hit;

`ifdef CPC_RAM1M_TESTPOINT_EN
    logic [4:0] tp_p1;

    // Test points lag the live state by one clock
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) tp_p1 <= '0;
        else       tp_p1 <= {ext_hit, bank[BANK_BITS-1], mode};
    end

    assign TP = tp_p1;
`else
    assign TP = '0;
`endif

endmodule

// File: tb/tb_cpc_ram1m_ctrl.sv
// Self-checking bench for cpc_ram1m_ctrl: directed scenarios for the
// OUT-capture timing, reset and strobe gating, then randomized OUT writes
// and memory accesses checked against a page-table reference model.
module tb_cpc_ram1m_ctrl;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        ENABLE;
    logic [15:0] A;
    logic [7:0]  D;
    logic        IOREQ_B, WR_B, MREQ_B, RFSH_B, RAMRD_B;
    logic [4:0]  HIADR;
    logic        RAMCS0_B, RAMCS1_B, RAMOE_B, RAMWE_B, RAMDIS;
    logic [4:0]  TP;

    int n_chk = 0;
    int n_err = 0;

    // Reference model state
    logic [2:0] m_mode;
    logic [3:0] m_bank;
    logic       m_en;
    int         page_tbl [8][4];

    always #5 CLK = ~CLK;

    cpc_ram1m_ctrl dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .ENABLE   (ENABLE),
        .A        (A),
        .D        (D),
        .IOREQ_B  (IOREQ_B),
        .WR_B     (WR_B),
        .MREQ_B   (MREQ_B),
        .RFSH_B   (RFSH_B),
        .RAMRD_B  (RAMRD_B),
        .HIADR    (HIADR),
        .RAMCS0_B (RAMCS0_B),
        .RAMCS1_B (RAMCS1_B),
        .RAMOE_B  (RAMOE_B),
        .RAMWE_B  (RAMWE_B),
        .RAMDIS   (RAMDIS),
        .TP       (TP)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = 3'd0;
        m_bank = 4'd0;
    endtask

    task automatic bus_idle();
        IOREQ_B = 1'b1;
        WR_B    = 1'b1;
        MREQ_B  = 1'b1;
        RFSH_B  = 1'b1;
        RAMRD_B = 1'b1;
    endtask

    // One complete OUT instruction with the strobes held for 'hold' clocks
    task automatic io_out(input logic [15:0] addr, input logic [7:0] data, input int hold);
        @(negedge CLK);
        A = addr; D = data; MREQ_B = 1'b1; IOREQ_B = 1'b0; WR_B = 1'b0;
        repeat (hold) @(negedge CLK);
        IOREQ_B = 1'b1; WR_B = 1'b1;
        @(negedge CLK);
        if (addr[15:11] == 5'b01111 && data[7:6] == 2'b11) begin
            m_mode = data[2:0];
            m_bank = {~addr[8], data[5:3]};
        end
    endtask

    // One memory access; strobes and HIADR compared to the page table
    task automatic mem_check(input string tag, input logic [15:0] addr,
                             input logic rd, input logic wr, input logic rfsh);
        int         pg;
        logic       hit;
        logic [4:0] exp_str;
        logic [4:0] exp_hi;
        @(negedge CLK);
        A = addr; IOREQ_B = 1'b1; MREQ_B = 1'b0;
        RAMRD_B = ~rd; WR_B = ~wr; RFSH_B = ~rfsh;
        #2;
        pg      = page_tbl[m_mode][addr[15:14]];
        hit     = (pg != 0) && m_en && !rfsh;
        exp_str = {~(hit & ~m_bank[3]), ~(hit & m_bank[3]), ~(hit & rd), ~(hit & wr), hit};
        chk({tag, "_strobes"}, {RAMCS0_B, RAMCS1_B, RAMOE_B, RAMWE_B, RAMDIS}, exp_str);
        if (hit) begin
            exp_hi = {m_bank[2:0], 2'(pg - 4)};
            chk({tag, "_hiadr"}, HIADR, exp_hi);
        end
        @(negedge CLK);
        bus_idle();
    endtask

    task automatic tp_check(input string tag);
`ifdef CPC_RAM1M_TESTPOINT_EN
        chk(tag, TP, {1'b0, m_bank[3], m_mode});
`else
        chk(tag, TP, 0);
`endif
    endtask

    initial begin
        logic [15:0] ra;
        logic [7:0]  rd8;

        page_tbl = '{'{0, 0, 0, 0}, '{0, 0, 0, 7}, '{4, 5, 6, 7}, '{0, 0, 0, 7},
                     '{0, 4, 0, 0}, '{0, 5, 0, 0}, '{0, 6, 0, 0}, '{0, 7, 0, 0}};
        RESET = 1'b1; ENABLE = 1'b1; m_en = 1'b1;
        A = 16'h0000; D = 8'h00;
        bus_idle();
        model_reset();
        repeat (2) @(negedge CLK);

        // Reset state: no expansion mapping anywhere
        mem_check("rst_c000", 16'hC000, 1'b1, 1'b0, 1'b0);
        mem_check("rst_4000", 16'h4000, 1'b0, 1'b1, 1'b0);
        tp_check("rst_tp");
        RESET = 1'b0;

        // Two-edge latency: A=&7FFF is both the port and slot 1
        @(negedge CLK);
        A = 16'h7FFF; D = 8'hC2; MREQ_B = 1'b0; IOREQ_B = 1'b0; WR_B = 1'b0;
        #2 chk("lat_e0", RAMDIS, 0);
        @(negedge CLK); chk("lat_e1", RAMDIS, 0);
        @(negedge CLK); chk("lat_e2", RAMDIS, 1);
        bus_idle();
        m_mode = 3'd2; m_bank = 4'd0;
        @(negedge CLK);

        // OUT &7FFF,&C2 and OUT &7EFF,&FF
        io_out(16'h7FFF, 8'hC2, 2);
        mem_check("m2_c000", 16'hC000, 1'b1, 1'b0, 1'b0);
        tp_check("m2_tp");
        io_out(16'h7EFF, 8'hFF, 3);
        mem_check("m7_4123", 16'h4123, 1'b1, 1'b0, 1'b0);
        mem_check("m7_c000", 16'hC000, 1'b1, 1'b0, 1'b0);
        tp_check("m7_tp");

        // Held OUT with D changing after capture: only the first value sticks
        @(negedge CLK);
        A = 16'h7FFF; D = 8'hC1; MREQ_B = 1'b0; IOREQ_B = 1'b0; WR_B = 1'b0;
        repeat (2) @(negedge CLK);
        D = 8'hC2;
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            chk("single_cap", RAMDIS, 0);
        end
        bus_idle();
        m_mode = 3'd1; m_bank = 4'd0;
        @(negedge CLK);
        mem_check("single_c000", 16'hC000, 1'b1, 1'b0, 1'b0);
        io_out(16'h7FFF, 8'hC2, 2);
        mem_check("after_rel", 16'h0010, 1'b0, 1'b1, 1'b0);

        // Refresh cycle in mode 2 must not select SRAM
        mem_check("rfsh", 16'hC000, 1'b1, 1'b0, 1'b1);

        // Reset in HOLD clears asynchronously; held cfg_hit is re-captured
        @(negedge CLK);
        A = 16'h7FFF; D = 8'hC2; MREQ_B = 1'b0; IOREQ_B = 1'b0; WR_B = 1'b0;
        repeat (3) @(negedge CLK);
        chk("pre_rst", RAMDIS, 1);
        RESET = 1'b1;
        #1;
        model_reset();
        chk("async_rst", RAMDIS, 0);
        tp_check("async_rst_tp");
        repeat (2) @(negedge CLK);
        RESET = 1'b0;
        @(negedge CLK); chk("recap_e1", RAMDIS, 0);
        @(negedge CLK); chk("recap_e2", RAMDIS, 1);
        bus_idle();
        m_mode = 3'd2; m_bank = 4'd0;
        @(negedge CLK);

        // Gate-array style write (D7:6=10) is ignored
        io_out(16'h7FFF, 8'h8C, 2);
        mem_check("ga_ignored", 16'h8000, 1'b1, 1'b0, 1'b0);
        tp_check("ga_tp");

        // ENABLE=0 blocks strobes but the register still updates
        @(negedge CLK); ENABLE = 1'b0; m_en = 1'b0;
        mem_check("dis_m2", 16'hC000, 1'b1, 1'b0, 1'b0);
        io_out(16'h7FFF, 8'hD2, 2);
        tp_check("dis_tp");
        @(negedge CLK); ENABLE = 1'b1; m_en = 1'b1;
        mem_check("reen", 16'hC000, 1'b1, 1'b0, 1'b0);

        // Randomized OUT writes, enable toggles and memory accesses
        for (int i = 0; i < 120; i++) begin
            case ($urandom_range(0, 5))
                0: begin
                    @(negedge CLK);
                    ENABLE = ($urandom_range(0, 3) != 0);
                    m_en   = ENABLE;
                end
                1, 2: begin
                    ra  = 16'($urandom);
                    rd8 = 8'($urandom);
                    if ($urandom_range(0, 3) != 0) ra[15:11] = 5'b01111;
                    if ($urandom_range(0, 3) != 0) rd8[7:6] = 2'b11;
                    io_out(ra, rd8, $urandom_range(1, 4));
                    tp_check("rnd_tp");
                end
                default: begin
                    mem_check("rnd_mem", 16'($urandom), 1'($urandom), 1'($urandom),
                              ($urandom_range(0, 4) == 0));
                end
            endcase
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
